// File: rtl/fir_pkg.sv
// Shared FIR definitions: default widths, sample/coefficient/accumulator types
// and a round+saturate helper for the default widths.
package fir_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_COEF_W = 8;
    localparam int DEF_FRAC   = 6;
    localparam int DEF_ACC_W  = DEF_DATA_W + DEF_COEF_W + 2;

    typedef logic signed [DEF_DATA_W-1:0] sample_t;
    typedef logic signed [DEF_COEF_W-1:0] coef_t;
    typedef logic signed [DEF_ACC_W-1:0]  acc_t;

    // One guard bit above the accumulator keeps the rounding add from wrapping.
    function automatic sample_t sat_round(input acc_t s);
        logic signed [DEF_ACC_W:0] r;
        r = {s[DEF_ACC_W-1], s} + (DEF_ACC_W+1)'(1 << (DEF_FRAC - 1));
        r = r >>> DEF_FRAC;
        if (r > (DEF_ACC_W+1)'((2 ** (DEF_DATA_W - 1)) - 1))
            return sample_t'((2 ** (DEF_DATA_W - 1)) - 1);
        else if (r < (DEF_ACC_W+1)'(-(2 ** (DEF_DATA_W - 1))))
            return sample_t'(-(2 ** (DEF_DATA_W - 1)));
        else
            return r[DEF_DATA_W-1:0];
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational round-half-up and saturate from accumulator width to sample width.
module fir_round_sat
    import fir_pkg::*;
#(
    parameter int ACC_W  = DEF_ACC_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC   = DEF_FRAC
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [DATA_W-1:0] y
);

    localparam int EXT_W = ACC_W + 1;
    // FRAC=0 means no rounding offset at all.
    localparam logic signed [EXT_W-1:0] HALF =
        (FRAC > 0) ? (EXT_W'(1) <<< ((FRAC > 0) ? FRAC - 1 : 0)) : '0;
    localparam logic signed [EXT_W-1:0] Y_MAX = EXT_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [EXT_W-1:0] Y_MIN = EXT_W'(-(2 ** (DATA_W - 1)));

    function automatic logic signed [EXT_W-1:0] round_shift(input logic signed [ACC_W-1:0] s);
        logic signed [EXT_W-1:0] t;
        t = {s[ACC_W-1], s} + HALF;
        return t >>> FRAC;
    endfunction

    function automatic logic signed [DATA_W-1:0] saturate(input logic signed [EXT_W-1:0] r);
        if (r > Y_MAX)
            return Y_MAX[DATA_W-1:0];
        else if (r < Y_MIN)
            return Y_MIN[DATA_W-1:0];
        else
            return r[DATA_W-1:0];
    endfunction

    always_comb begin
        y = saturate(round_shift(acc));
    end

endmodule

// File: rtl/fir4_mac_datapath.sv
// 4-tap time-multiplexed FIR MAC: delay line, coefficient bank, tap mux,
// multiplier, accumulator and registered rounded/saturated output.
module fir4_mac_datapath
    import fir_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W,
    parameter int FRAC   = DEF_FRAC
) (
    input  logic                     ph1,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] sample_in,
    input  logic                     sample_load,
    input  logic [1:0]               tap_sel,
    input  logic                     clear_accum,
    input  logic                     coef_we,
    input  logic [1:0]               coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic signed [DATA_W-1:0] y_out,
    output logic                     y_valid
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = DATA_W + COEF_W + 2;

    logic signed [DATA_W-1:0] x [4];
    logic signed [COEF_W-1:0] c [4];
    logic signed [ACC_W-1:0]  acc;

    logic signed [PROD_W-1:0] prod_p0;
    logic signed [ACC_W-1:0]  sum_p0;
    logic signed [DATA_W-1:0] y_next_p0;
    logic                     vld_p0;

    // Stage p0: tap select, multiply and running sum, all from current state.
    always_comb begin
        prod_p0 = x[tap_sel] * c[tap_sel];
        sum_p0  = acc + ACC_W'(prod_p0);
        vld_p0  = clear_accum;
    end

    fir_round_sat #(
        .ACC_W  (ACC_W),
        .DATA_W (DATA_W),
        .FRAC   (FRAC)
    ) u_round_sat (
        .acc (sum_p0),
        .y   (y_next_p0)
    );

    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) x[i] <= '0;
        end else if (sample_load) begin
            x[3] <= x[2];
            x[2] <= x[1];
            x[1] <= x[0];
            x[0] <= sample_in;
        end
    end

    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) c[i] <= '0;
        end else if (coef_we) begin
            c[coef_addr] <= coef_data;
        end
    end

    // Stage p1: close the sum into the output register on clear_accum.
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            acc     <= '0;
            y_out   <= '0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= vld_p0;
            if (vld_p0) begin
                acc   <= '0;
                y_out <= y_next_p0;
            end else begin
                acc   <= sum_p0;
            end
        end
    end

endmodule

// File: tb/tb_fir4_mac_datapath.sv
// Scoreboard bench for fir4_mac_datapath: a behavioural FIR model pushes
// expected outputs per clear_accum cycle; a negedge monitor pops and compares.
module tb_fir4_mac_datapath;

    logic              ph1;
    logic              reset;
    logic signed [7:0] sample_in;
    logic              sample_load;
    logic [1:0]        tap_sel;
    logic              clear_accum;
    logic              coef_we;
    logic [1:0]        coef_addr;
    logic signed [7:0] coef_data;
    logic signed [7:0] y_out;
    logic              y_valid;

    int n_cmp = 0;
    int n_err = 0;
    int sb[$];
    int mx[4];
    int mc[4];
    int macc;
    int cyc = 0;
    int last_vld = -1;
    bit period_on = 0;

    fir4_mac_datapath dut (
        .ph1         (ph1),
        .reset       (reset),
        .sample_in   (sample_in),
        .sample_load (sample_load),
        .tap_sel     (tap_sel),
        .clear_accum (clear_accum),
        .coef_we     (coef_we),
        .coef_addr   (coef_addr),
        .coef_data   (coef_data),
        .y_out       (y_out),
        .y_valid     (y_valid)
    );

    initial ph1 = 0;
    always #5 ph1 = ~ph1;
    always @(posedge ph1) cyc++;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_y(input int s);
        int r;
        r = (s + 32) >>> 6;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mx[i] = 0;
            mc[i] = 0;
        end
        macc = 0;
        sb.delete();
    endtask

    task automatic step(input int t, input bit ld, input bit clr, input bit we,
                        input int a, input int cd, input int smp);
        int p;
        tap_sel     = 2'(t);
        sample_load = ld;
        clear_accum = clr;
        coef_we     = we;
        coef_addr   = 2'(a);
        coef_data   = 8'(cd);
        sample_in   = 8'(smp);
        p = mx[t] * mc[t];
        if (clr) begin
            sb.push_back(exp_y(macc + p));
            macc = 0;
        end else begin
            macc += p;
        end
        if (ld) begin
            mx[3] = mx[2];
            mx[2] = mx[1];
            mx[1] = mx[0];
            mx[0] = smp;
        end
        if (we) mc[a] = cd;
        @(posedge ph1);
        #1;
    endtask

    task automatic wr(input int a, input int cd);
        step(0, 0, 0, 1, a, cd, 0);
    endtask

    task automatic frame(input int smp);
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(2, 0, 0, 0, 0, 0, 0);
        step(3, 1, 1, 0, 0, 0, smp);
    endtask

    always @(negedge ph1) begin
        if (reset && y_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", 1, 0);
            end else begin
                chk("y_out", int'(y_out), sb.pop_front());
            end
            if (period_on) begin
                if (last_vld >= 0) chk("valid_period", cyc - last_vld, 4);
                last_vld = cyc;
            end
        end
    end

    initial begin
        reset = 0;
        sample_in = 0; sample_load = 0; tap_sel = 0; clear_accum = 0;
        coef_we = 0; coef_addr = 0; coef_data = 0;
        model_reset();
        #3;
        chk("rst_y_out", int'(y_out), 0);
        chk("rst_y_valid", int'(y_valid), 0);
        repeat (2) @(posedge ph1);
        #2 reset = 1;
        @(posedge ph1);
        #1;

        // Impulse response
        wr(0, 64); wr(1, 32); wr(2, 16); wr(3, 8);
        frame(100);
        for (int i = 0; i < 5; i++) frame(0);

        // Saturation both ways
        for (int i = 0; i < 4; i++) wr(i, 127);
        for (int i = 0; i < 5; i++) frame(127);
        for (int i = 0; i < 5; i++) frame(-128);

        // Async reset mid-sum with nonzero accumulator and output
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        #1 reset = 0;
        #1;
        chk("midrst_y_out", int'(y_out), 0);
        chk("midrst_y_valid", int'(y_valid), 0);
        model_reset();
        #1 reset = 1;
        frame(77);
        step(0, 0, 0, 0, 0, 0, 0);

        // Coefficient write during tap-1 cycle of a frame
        wr(0, 0); wr(1, 0); wr(2, 0); wr(3, 64);
        frame(50); frame(0); frame(0); frame(0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 3, 0, 0);
        step(2, 0, 0, 0, 0, 0, 0);
        step(3, 1, 1, 0, 0, 0, 0);

        // Simultaneous load, clear and coefficient write
        for (int i = 0; i < 4; i++) wr(i, 64);
        frame(10); frame(20); frame(30); frame(40);
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(2, 0, 0, 0, 0, 0, 0);
        step(3, 1, 1, 1, 3, -64, 99);
        frame(0);
        frame(0);

        // Random frames with fixed random coefficients, checking output cadence
        for (int i = 0; i < 4; i++) wr(i, int'($urandom_range(0, 255)) - 128);
        last_vld = -1;
        period_on = 1;
        for (int i = 0; i < 250; i++) frame(int'($urandom_range(0, 255)) - 128);
        period_on = 0;

        // Free-form random control, including out-of-order taps and mid-sum writes
        for (int i = 0; i < 60; i++) begin
            step(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 255)) - 128,
                 int'($urandom_range(0, 255)) - 128);
        end
        frame(0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
